// File: rtl/disp_scan_ctrl_pkg.sv
// rtl/disp_scan_ctrl_pkg.sv - shared constants, phase type and width helpers for the scan controller
package disp_pkg;

    // Segment lines are active-low, so all ones means every segment is dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex-to-segment patterns {g,f,e,d,c,b,a}, active-low; entry n is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - host and display signals of the scan controller
interface disp_scan_ctrl_if #(
    parameter int N_DIGITS = 8
) ();

    logic [4*N_DIGITS-1:0] data_i;
    logic [N_DIGITS-1:0]   en_i;
    logic [N_DIGITS-1:0]   dp_i;
    logic                  blank_lz_i;
    logic                  load_i;

    logic [6:0]            seg_o;
    logic                  dp_o;
    logic [N_DIGITS-1:0]   an_o;
    logic                  frame_o;
    logic                  pend_o;

    modport master (
        output data_i, en_i, dp_i, blank_lz_i, load_i,
        input  seg_o, dp_o, an_o, frame_o, pend_o
    );

    modport slave (
        input  data_i, en_i, dp_i, blank_lz_i, load_i,
        output seg_o, dp_o, an_o, frame_o, pend_o
    );

endinterface

// File: rtl/dectohex.sv
// rtl/dectohex.sv - combinational hex nibble to seven-segment decoder
module dectohex
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed seven-segment scan controller with frame-aligned updates
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_ctrl_if.slave bus
);

    localparam int CW = cnt_width(SCAN_DIV);
    localparam int IW = cnt_width(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    logic [CW-1:0]       c;
    logic [IW-1:0]       idx;

    logic [DW-1:0]       act_data, pnd_data;
    logic [N_DIGITS-1:0] act_en, act_dp, pnd_en, pnd_dp;
    logic                act_blz, pnd_blz, pend;

    logic [6:0]          seg_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] an_q;
    logic                frame_q;

    logic                c_wrap, boundary, visible, zero_run;
    phase_t              phase;
    logic [N_DIGITS-1:0] lz;
    logic [3:0]          nib;
    logic [6:0]          seg_dec, seg_d;
    logic                dp_d;
    logic [N_DIGITS-1:0] an_d;

    assign c_wrap   = (c == CW'(SCAN_DIV - 1));
    assign boundary = c_wrap && (idx == IW'(N_DIGITS - 1));
    assign phase    = (c < CW'(BLANK)) ? PH_BLANK : PH_DRIVE;
    assign nib      = act_data[{idx, 2'b00} +: 4];

    dectohex u_dec (
        .hex (nib),
        .seg (seg_dec)
    );

    // Prescaler walks the slot; each wrap advances the digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c   <= '0;
            idx <= '0;
        end else if (c_wrap) begin
            c   <= '0;
            idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            c   <= c + 1'b1;
        end
    end

    // Double buffer: loads park in pending; a load on the boundary itself bypasses to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data <= '0;
            act_en   <= '0;
            act_dp   <= '0;
            act_blz  <= 1'b0;
            pnd_data <= '0;
            pnd_en   <= '0;
            pnd_dp   <= '0;
            pnd_blz  <= 1'b0;
            pend     <= 1'b0;
        end else if (boundary) begin
            if (bus.load_i) begin
                act_data <= bus.data_i;
                act_en   <= bus.en_i;
                act_dp   <= bus.dp_i;
                act_blz  <= bus.blank_lz_i;
            end else if (pend) begin
                act_data <= pnd_data;
                act_en   <= pnd_en;
                act_dp   <= pnd_dp;
                act_blz  <= pnd_blz;
            end
            pend <= 1'b0;
        end else if (bus.load_i) begin
            pnd_data <= bus.data_i;
            pnd_en   <= bus.en_i;
            pnd_dp   <= bus.dp_i;
            pnd_blz  <= bus.blank_lz_i;
            pend     <= 1'b1;
        end
    end

    // lz[k] is set when nibbles N_DIGITS-1 down to k are all zero.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_data[4*k +: 4] == 4'h0);
            lz[k]    = zero_run;
        end
    end

    // Decide whether the current digit is lit and form the next output values.
    always_comb begin
        visible = act_en[idx] && (phase == PH_DRIVE)
                  && !(act_blz && (idx != '0) && lz[idx]);
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        an_d    = '1;
        if (visible) begin
            seg_d     = seg_dec;
            dp_d      = ~act_dp[idx];
            an_d[idx] = 1'b0;
        end
    end

    // Register every display output so pins never glitch with the mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= boundary;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;
    assign bus.pend_o  = pend;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

    localparam int N   = 8;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRM = N * DIV;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic        blz;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] sb [$];
    cfg_t        cur;
    cfg_t        none_c;

    always #5 clk = ~clk;

    disp_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    disp_scan_ctrl #(
        .N_DIGITS (N),
        .SCAN_DIV (DIV),
        .BLANK    (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg, dp, frame, pend} for sample p of a frame showing cfg a.
    function automatic logic [17:0] ref_sample(input cfg_t a, input int p, input logic pd);
        int          k;
        int          cc;
        logic        vis;
        logic [3:0]  nb;
        logic [31:0] sh;
        logic [7:0]  an;
        logic [6:0]  sg;
        logic        dpo;
        cc  = p % DIV;
        k   = p / DIV;
        sh  = a.d >> (4 * k);
        nb  = sh[3:0];
        vis = a.en[k] && (cc >= BLK) && !(a.blz && (k != 0) && (sh == 32'h0));
        an  = vis ? ~(8'h01 << k) : 8'hFF;
        sg  = vis ? ref_seg(nb) : 7'h7F;
        dpo = vis ? ~a.dp[k] : 1'b1;
        return {an, sg, dpo, (p == FRM - 1), pd};
    endfunction

    function automatic logic [17:0] dut_out();
        return {bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o, bus.pend_o};
    endfunction

    task automatic drive_cfg(input cfg_t v);
        bus.data_i     = v.d;
        bus.en_i       = v.en;
        bus.dp_i       = v.dp;
        bus.blank_lz_i = v.blz;
    endtask

    // Run samples 0..stop_at-1 of a frame showing act, with up to two loads at sample la / lb.
    task automatic run_frame(input string name, input cfg_t act, input int la, input cfg_t va,
                             input int lb, input cfg_t vb, input int stop_at, output cfg_t nxt);
        logic [17:0] e;
        logic [17:0] g;
        logic        pd;
        for (int p = 0; p < stop_at; p++) begin
            pd = (p < FRM - 1) && ((la >= 0 && la < FRM - 1 && la <= p) ||
                                   (lb >= 0 && lb < FRM - 1 && lb <= p));
            sb.push_back(ref_sample(act, p, pd));
        end
        for (int p = 0; p < stop_at; p++) begin
            bus.load_i = 1'b0;
            if (p == la) begin
                drive_cfg(va);
                bus.load_i = 1'b1;
            end else if (p == lb) begin
                drive_cfg(vb);
                bus.load_i = 1'b1;
            end
            @(negedge clk);
            e = sb.pop_front();
            g = dut_out();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s p=%0d got an=%h seg=%b dp=%b fr=%b pd=%b want an=%h seg=%b dp=%b fr=%b pd=%b",
                         name, p, g[17:10], g[9:3], g[2], g[1], g[0],
                         e[17:10], e[9:3], e[2], e[1], e[0]);
            end
        end
        bus.load_i = 1'b0;
        nxt = act;
        if (la >= 0 && la < stop_at) nxt = va;
        if (lb >= 0 && lb < stop_at && lb > la) nxt = vb;
    endtask

    task automatic check_dark(input string name);
        logic [17:0] g;
        g = dut_out();
        checks++;
        if (g !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s got an=%h seg=%b dp=%b fr=%b pd=%b want an=ff seg=1111111 dp=1 fr=0 pd=0",
                     name, g[17:10], g[9:3], g[2], g[1], g[0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_cfg(none_c);
        bus.load_i = 1'b0;
        repeat (3) @(negedge clk);
        check_dark("reset_values");
        rst_n = 1'b1;
        cur = none_c;
        run_frame("reset_dark_frame", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_basic();
        cfg_t v;
        v = '{d: 32'h01234567, en: 8'hFF, dp: 8'h00, blz: 1'b0};
        run_frame("basic_load", cur, 5, v, -1, none_c, FRM, cur);
        run_frame("basic_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_leading_zero();
        cfg_t v;
        v = '{d: 32'h000000A0, en: 8'hFF, dp: 8'h00, blz: 1'b1};
        run_frame("lz_load", cur, 40, v, -1, none_c, FRM, cur);
        run_frame("lz_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_midframe_load();
        cfg_t v;
        v = '{d: 32'hFEDCBA98, en: 8'hFF, dp: 8'h81, blz: 1'b0};
        run_frame("mid_load_slot3", cur, 3 * DIV + 1, v, -1, none_c, FRM, cur);
        run_frame("mid_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_last_wins();
        cfg_t a;
        cfg_t b;
        a = '{d: 32'h11111111, en: 8'hFF, dp: 8'hFF, blz: 1'b0};
        b = '{d: 32'h00C0DE00, en: 8'hFF, dp: 8'h10, blz: 1'b1};
        run_frame("last_wins_load", cur, 10, a, 50, b, FRM, cur);
        run_frame("last_wins_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_boundary_load();
        cfg_t a;
        cfg_t b;
        a = '{d: 32'h22222222, en: 8'hFF, dp: 8'h00, blz: 1'b0};
        b = '{d: 32'h88888888, en: 8'h05, dp: 8'h04, blz: 1'b0};
        run_frame("boundary_load", cur, 10, a, FRM - 1, b, FRM, cur);
        run_frame("masks_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    task automatic test_async_reset();
        cfg_t v;
        v = '{d: 32'h01234567, en: 8'hFF, dp: 8'h10, blz: 1'b0};
        run_frame("async_prep", cur, 20, v, -1, none_c, FRM, cur);
        run_frame("async_pre_drive", cur, -1, none_c, -1, none_c, 4 * DIV + 5, cur);
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset_immediate");
        repeat (2) @(negedge clk);
        check_dark("async_reset_held");
        rst_n = 1'b1;
        cur = none_c;
        run_frame("async_after_dark", cur, 30, v, -1, none_c, FRM, cur);
        run_frame("async_after_show", cur, -1, none_c, -1, none_c, FRM, cur);
    endtask

    initial begin
        none_c = '{d: 32'h0, en: 8'h00, dp: 8'h00, blz: 1'b0};
        rst_n = 1'b0;
        bus.load_i = 1'b0;
        drive_cfg(none_c);
        test_reset();
        test_basic();
        test_leading_zero();
        test_midframe_load();
        test_last_wins();
        test_boundary_load();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the board's common-anode seven-segment bank. It holds an N-digit hex value and walks a digit index across the anodes. One shared hex-to-segment decoder converts the selected nibble each slot, and the controller gates the decoder's output onto the segment lines. Updates from the host are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

## Interface
- N_DIGITS, 8: digits in the bank (2..8).
- SCAN_DIV, 100000: clock cycles per digit slot (≥ 2).
- BLANK, 4: cycles at the start of each slot with all anodes off, for ghost suppression (1 ≤ BLANK < SCAN_DIV).
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- data_i  in  4*N_DIGITS  hex nibbles; digit 0 = bits [3:0].
- en_i  in  N_DIGITS  per-digit enable mask.
- dp_i  in  N_DIGITS  decimal-point request, active-high.
- blank_lz_i  in  1  leading-zero blanking enable.
- load_i  in  1  one-cycle strobe that captures data_i/en_i/dp_i/blank_lz_i.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low.
- an_o  out  N_DIGITS  anode select, active-low, at most one low.
- frame_o  out  1  one-cycle pulse after each complete scan.
- pend_o  out  1  a captured update is waiting for the frame boundary.

## Operation
- Counters:
  - Prescaler `c` runs 0..SCAN_DIV-1 and wraps.
  - On wrap, `idx` advances 0..N_DIGITS-1, mod N_DIGITS.
- Phase per slot:
  - PH_BLANK when c < BLANK: all anodes off.
  - PH_DRIVE otherwise: digit `idx` driven.
- Active registers: data, en, dp, blz. Pending registers: the same set plus pend flag.
- load_i:
  - Captures into pending and sets pend.
  - A second load before the boundary overwrites pending; last wins.
- Frame boundary is the cycle with c = SCAN_DIV-1 and idx = N_DIGITS-1.
  - If pend is set, pending is copied to active and pend clears.
  - If load_i coincides with the boundary, data_i etc. go straight to active and pend stays 0; this takes priority over an older pending value.
- Digit visibility. Digit k is visible iff all of the following hold:
  - en[k] = 1;
  - the current phase is PH_DRIVE;
  - k is not leading-blanked.
- Leading-blanked means blz = 1, k ≠ 0, and nibbles N_DIGITS-1..k are all zero. Digit 0 is never leading-blanked.
- Visible digit: an_o[k] = 0, seg_o = decode(nibble k), dp_o = ~dp[k].
- Invisible digit: an_o all 1, seg_o = 7'h7F, dp_o = 1.
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset values:
  - seg_o = 7'h7F, dp_o = 1, an_o = all 1, frame_o = 0, pend_o = 0.
  - c = 0, idx = 0.
  - Active and pending registers all 0 (nothing lit until the first load).
- Reset mid-operation: outputs take reset values immediately and asynchronously. After release, the scan restarts at slot 0, c = 0.

## Timing
- All outputs are registered and reflect the counter state of the previous cycle (1-cycle latency).
- For slot k starting at cycle T (c = 0):
  - an_o is all 1 for cycles T+1..T+BLANK.
  - Digit k is driven for cycles T+BLANK+1..T+SCAN_DIV.
- frame_o is high exactly one cycle, the cycle after the boundary. Period = N_DIGITS*SCAN_DIV.
- pend_o:
  - Goes high the cycle after load_i.
  - Goes low the cycle after the boundary, together with frame_o.
- New data is first visible in slot 0 of the next frame.

## Structure
- Shared package `disp_pkg`:
  - segment-pattern constants SEG_OFF = 7'h7F and the 16-entry table;
  - phase enum {PH_BLANK, PH_DRIVE};
  - $clog2 helpers for prescaler and index widths.
- Sub-module: the existing combinational `dectohex` decoder, one instance fed by the nibble mux. Its table must match the one above (digit 5 = 0010010, digit 11 = 0000011, digit 13 = 0100001).

## Test plan
Benches use N_DIGITS=8, SCAN_DIV=8, BLANK=2.
- Reset: hold rst_n=0, then release. Outputs must show seg_o=7F, an_o=FF, dp_o=1, frame_o=0, pend_o=0, and stay dark through the whole first frame.
- Load 0x01234567, en=FF, dp=0, blz=0. In the following frame, slot 0 gives an_o=FE, seg_o=1111000; slot 2 gives seg_o=0010010; slot 7 gives an_o=7F, seg_o=1000000. Blank cycles give an_o=FF.
- Leading-zero blanking: load 0x000000A0 with blz=1. Slots 7..2 show an_o=FF. Slot 1 shows seg_o=0001000; slot 0 shows seg_o=1000000.
- Mid-frame load during slot 3: pend_o=1 the next cycle and the old value persists through slot 7. frame_o pulses, pend_o drops, and the new value appears from slot 0.
- Masks: en=0x05, dp=0x04 with data 0x88888888. Only slots 0 and 2 light. dp_o=0 only in slot 2.
- Async reset asserted mid-drive in slot 4: an_o=FF is seen before the next clk edge. After release, the first lit slot is slot 0.
